// File: rtl/uop_sequencer_pkg.sv
// rtl/uop_sequencer_pkg.sv - shared microcode encodings for the curve point engine sequencer
// Purpose: microword field positions, one-hot opcodes, operand/exec encodings,
//          FSM state encoding and the dispatch command record.
// Ports:   none (package)
package uop_sequencer_pkg;

   localparam int UOP_W = 20;
   localparam int OPC_W = 6;
   localparam int SEL_W = 4;
   localparam int PC_W  = 6;

   // Microword field bit positions
   localparam int OPC_HI  = 19;
   localparam int OPC_LO  = 14;
   localparam int SRC1_HI = 13;
   localparam int SRC1_LO = 10;
   localparam int SRC2_HI = 9;
   localparam int SRC2_LO = 6;
   localparam int DST_HI  = 5;
   localparam int DST_LO  = 2;
   localparam int EXEC_HI = 1;
   localparam int EXEC_LO = 0;

   // One-hot opcodes; all-zero marks the end of a program
   localparam logic [OPC_W-1:0] OPCODE_RDY = 6'b000000;
   localparam logic [OPC_W-1:0] OPCODE_CMP = 6'b000001;
   localparam logic [OPC_W-1:0] OPCODE_MOV = 6'b000010;
   localparam logic [OPC_W-1:0] OPCODE_ADD = 6'b000100;
   localparam logic [OPC_W-1:0] OPCODE_SUB = 6'b001000;
   localparam logic [OPC_W-1:0] OPCODE_MUL = 6'b010000;
   localparam logic [OPC_W-1:0] OPCODE_INV = 6'b100000;

   // Operand bank selects
   localparam logic [SEL_W-1:0] UOP_SRC_ZERO = 4'd0;
   localparam logic [SEL_W-1:0] UOP_SRC_ONE  = 4'd1;
   localparam logic [SEL_W-1:0] UOP_SRC_RX   = 4'd2;
   localparam logic [SEL_W-1:0] UOP_SRC_RY   = 4'd3;
   localparam logic [SEL_W-1:0] UOP_SRC_RZ   = 4'd4;
   localparam logic [SEL_W-1:0] UOP_DST_RX   = 4'd2;
   localparam logic [SEL_W-1:0] UOP_DST_RY   = 4'd3;
   localparam logic [SEL_W-1:0] UOP_DST_RZ   = 4'd4;
   localparam logic [SEL_W-1:0] UOP_DST_T0   = 4'd5;

   // Execute conditions; 11 is reserved and behaves as ALWAYS
   localparam logic [1:0] UOP_EXEC_ALWAYS      = 2'b00;
   localparam logic [1:0] UOP_EXEC_IF_FLAG     = 2'b01;
   localparam logic [1:0] UOP_EXEC_IF_NOT_FLAG = 2'b10;
   localparam logic [1:0] UOP_EXEC_RSVD        = 2'b11;

   localparam logic [PC_W-1:0] PC_LAST = 6'd63;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LATCH  = 3'd2,
      ST_DECODE = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WAIT   = 3'd5
   } state_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [SEL_W-1:0] src1;
      logic [SEL_W-1:0] src2;
      logic [SEL_W-1:0] dst;
   } dp_cmd_t;

   function automatic logic [UOP_W-1:0] uop_word(
      input logic [OPC_W-1:0] opc,
      input logic [SEL_W-1:0] s1,
      input logic [SEL_W-1:0] s2,
      input logic [SEL_W-1:0] d,
      input logic [1:0]       ex
   );
      return {opc, s1, s2, d, ex};
   endfunction

endpackage

// File: rtl/uop_sequencer_if.sv
// rtl/uop_sequencer_if.sv - start/ROM/datapath bundle of the microcode sequencer
// Purpose: groups the start handshake, microprogram ROM port and datapath
//          dispatch port.
// Ports:   ena/rdy start handshake, uop_addr/uop_data ROM port,
//          dp_ena/dp_opcode/dp_src1/dp_src2/dp_dst dispatch, dp_rdy/dp_flag completion.
//          master = sequencer side, slave = environment side.
interface uop_sequencer_if;
   import uop_sequencer_pkg::*;

   logic             ena;
   logic             rdy;
   logic [PC_W-1:0]  uop_addr;
   logic [UOP_W-1:0] uop_data;
   logic             dp_ena;
   logic [OPC_W-1:0] dp_opcode;
   logic [SEL_W-1:0] dp_src1;
   logic [SEL_W-1:0] dp_src2;
   logic [SEL_W-1:0] dp_dst;
   logic             dp_rdy;
   logic             dp_flag;

   modport master (
      input  ena, uop_data, dp_rdy, dp_flag,
      output rdy, uop_addr, dp_ena, dp_opcode, dp_src1, dp_src2, dp_dst
   );

   modport slave (
      output ena, uop_data, dp_rdy, dp_flag,
      input  rdy, uop_addr, dp_ena, dp_opcode, dp_src1, dp_src2, dp_dst
   );

endinterface

// File: rtl/uop_decode.sv
// rtl/uop_decode.sv - combinational microword decoder
// Purpose: splits a microword into dispatch fields, detects the end-of-program
//          word and evaluates the execute condition against the flag.
// Ports:   ir in (microword), flag in (last CMP result),
//          cmd out (dispatch fields), is_rdy/is_cmp/cond_ok out.
module uop_decode
   import uop_sequencer_pkg::*;
(
   input  logic [UOP_W-1:0] ir,
   input  logic             flag,
   output dp_cmd_t          cmd,
   output logic             is_rdy,
   output logic             is_cmp,
   output logic             cond_ok
);

   logic [1:0] exec_f;

   assign cmd.opcode = ir[OPC_HI:OPC_LO];
   assign cmd.src1   = ir[SRC1_HI:SRC1_LO];
   assign cmd.src2   = ir[SRC2_HI:SRC2_LO];
   assign cmd.dst    = ir[DST_HI:DST_LO];
   assign exec_f     = ir[EXEC_HI:EXEC_LO];

   // End of program is decided by the opcode alone, whatever exec holds
   assign is_rdy = (cmd.opcode == OPCODE_RDY);
   assign is_cmp = (cmd.opcode == OPCODE_CMP);

   always_comb begin
      cond_ok = 1'b1;
      case (exec_f)
         UOP_EXEC_IF_FLAG:     cond_ok = flag;
         UOP_EXEC_IF_NOT_FLAG: cond_ok = ~flag;
         default:              cond_ok = 1'b1;
      endcase
   end

endmodule

// File: rtl/uop_sequencer.sv
// rtl/uop_sequencer.sv - microcode sequencer driving the modular-arithmetic datapath
// Purpose: fetches microwords from a synchronous ROM, decodes them and issues
//          one-cycle dispatches, waiting for completion of each.
// Ports:   clk, rst (sync active-high), bus (uop_sequencer_if.master).
module uop_sequencer
   import uop_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   uop_sequencer_if.master bus
);

   state_t           state;
   state_t           state_nxt;
   logic [PC_W-1:0]  pc;
   logic [UOP_W-1:0] ir;
   logic             flag;
   dp_cmd_t          cmd_q;

   dp_cmd_t          dec_cmd;
   logic             dec_rdy;
   logic             dec_cmp;
   logic             dec_ok;

   uop_decode u_decode (
      .ir      (ir),
      .flag    (flag),
      .cmd     (dec_cmd),
      .is_rdy  (dec_rdy),
      .is_cmp  (dec_cmp),
      .cond_ok (dec_ok)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.ena) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_LATCH;
         ST_LATCH:  state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (dec_rdy)      state_nxt = ST_IDLE;
            else if (!dec_ok) state_nxt = ST_FETCH;
            else              state_nxt = ST_EXEC;
         end
         ST_EXEC:   state_nxt = ST_WAIT;
         ST_WAIT: begin
            // Last ROM address ends the program instead of wrapping to 0
            if (bus.dp_rdy) state_nxt = (pc == PC_LAST) ? ST_IDLE : ST_FETCH;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Output logic; rdy is exactly "sitting in IDLE"
   always_comb begin
      bus.rdy    = 1'b0;
      bus.dp_ena = 1'b0;
      case (state)
         ST_IDLE: bus.rdy    = 1'b1;
         ST_EXEC: bus.dp_ena = 1'b1;
         default: ;
      endcase
   end

   // Program counter, instruction register, flag and held dispatch fields
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= '0;
         ir    <= '0;
         flag  <= 1'b0;
         cmd_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.ena) begin
                  pc   <= '0;
                  flag <= 1'b0;
               end
            end
            ST_LATCH: ir <= bus.uop_data;
            ST_DECODE: begin
               if (!dec_rdy) begin
                  if (dec_ok) cmd_q <= dec_cmd;
                  else        pc    <= pc + 6'd1;
               end
            end
            ST_WAIT: begin
               if (bus.dp_rdy) begin
                  if (dec_cmp)        flag <= bus.dp_flag;
                  if (pc != PC_LAST)  pc   <= pc + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.uop_addr  = pc;
   assign bus.dp_opcode = cmd_q.opcode;
   assign bus.dp_src1   = cmd_q.src1;
   assign bus.dp_src2   = cmd_q.src2;
   assign bus.dp_dst    = cmd_q.dst;

endmodule

// File: tb/tb_uop_sequencer.sv
// tb/tb_uop_sequencer.sv - directed scoreboard bench for uop_sequencer
// Purpose: drives programs through a ROM model and a datapath responder,
//          predicts every dispatch and program latency, and compares.
// Ports:   none (top-level bench)
module tb_uop_sequencer;
   import uop_sequencer_pkg::*;

   typedef struct packed {
      logic [PC_W-1:0] addr;
      dp_cmd_t         cmd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uop_sequencer_if bus ();

   uop_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [UOP_W-1:0] rom [64];
   exp_t             sb[$];

   // Responder configuration and state
   int   base_delay = 1;
   int   slow_idx   = -1;
   int   slow_delay = 1;
   int   resp_cnt   = 0;
   int   resp_idx   = 0;
   logic noise      = 1'b0;
   logic flag_cfg   = 1'b0;

   // Monitor state
   logic            mon_en    = 1'b0;
   int              disp_cnt  = 0;
   int              hold_bad  = 0;
   int              addr_back = 0;
   logic [PC_W-1:0] prev_addr = '0;
   dp_cmd_t         last_cmd  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Synchronous ROM: data valid one cycle after the address
   always @(posedge clk) bus.uop_data <= rom[bus.uop_addr];

   // Datapath model: completes each dispatch after a configurable delay;
   // with noise set it also raises dp_rdy whenever no operation is pending
   always @(negedge clk) begin
      if (bus.dp_ena) begin
         resp_cnt = (resp_idx == slow_idx) ? slow_delay : base_delay;
         resp_idx++;
         bus.dp_rdy = noise;
      end else if (resp_cnt > 0) begin
         resp_cnt--;
         bus.dp_rdy = (resp_cnt == 0);
      end else begin
         bus.dp_rdy = noise;
      end
      bus.dp_flag = flag_cfg;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.dp_ena) begin
            exp_t e;
            disp_cnt++;
            chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("disp_addr", {26'd0, bus.uop_addr}, {26'd0, e.addr});
               chk("disp_cmd", {14'd0, bus.dp_opcode, bus.dp_src1, bus.dp_src2, bus.dp_dst},
                   {14'd0, e.cmd});
               last_cmd = e.cmd;
            end
         end else if ({bus.dp_opcode, bus.dp_src1, bus.dp_src2, bus.dp_dst} !== last_cmd) begin
            hold_bad++;
         end
         if (!bus.rdy) begin
            if (bus.uop_addr < prev_addr) addr_back++;
            prev_addr = bus.uop_addr;
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = '0;
   endtask

   task automatic push(input int addr, input logic [OPC_W-1:0] opc, input logic [SEL_W-1:0] s1,
                       input logic [SEL_W-1:0] s2, input logic [SEL_W-1:0] d);
      exp_t e;
      e.addr       = addr[PC_W-1:0];
      e.cmd.opcode = opc;
      e.cmd.src1   = s1;
      e.cmd.src2   = s2;
      e.cmd.dst    = d;
      sb.push_back(e);
   endtask

   task automatic load_init();
      clear_rom();
      rom[0] = uop_word(OPCODE_MOV, UOP_SRC_ONE,  UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_ALWAYS);
      rom[1] = uop_word(OPCODE_MOV, UOP_SRC_ONE,  UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_ALWAYS);
      rom[2] = uop_word(OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RZ, UOP_EXEC_ALWAYS);
      rom[3] = uop_word(OPCODE_RDY, 4'd0, 4'd0, 4'd0, UOP_EXEC_RSVD);
      sb.delete();
      push(0, OPCODE_MOV, UOP_SRC_ONE,  UOP_SRC_ZERO, UOP_DST_RX);
      push(1, OPCODE_MOV, UOP_SRC_ONE,  UOP_SRC_ZERO, UOP_DST_RY);
      push(2, OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RZ);
   endtask

   task automatic load_cond();
      clear_rom();
      rom[0] = uop_word(OPCODE_CMP, UOP_SRC_RX,  UOP_SRC_RY,   UOP_DST_T0, UOP_EXEC_ALWAYS);
      rom[1] = uop_word(OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RZ, UOP_EXEC_IF_NOT_FLAG);
      rom[2] = uop_word(OPCODE_ADD, UOP_SRC_RX,  UOP_SRC_RY,   UOP_DST_RZ, UOP_EXEC_IF_FLAG);
      rom[3] = '0;
      sb.delete();
      push(0, OPCODE_CMP, UOP_SRC_RX, UOP_SRC_RY, UOP_DST_T0);
   endtask

   task automatic run_prog(input string tag, input int exp_lat, input int exp_disp,
                           input int exp_final, input int glitch);
      int cyc;
      disp_cnt  = 0;
      hold_bad  = 0;
      addr_back = 0;
      prev_addr = '0;
      resp_idx  = 0;
      @(negedge clk);
      bus.ena = 1'b1;
      @(negedge clk);
      bus.ena = 1'b0;
      chk({tag, "_rdy_fall"}, {31'd0, bus.rdy}, 32'd0);
      cyc = 0;
      while (!bus.rdy && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.ena = (glitch != 0 && (cyc == glitch || cyc == glitch + 7));
      end
      bus.ena = 1'b0;
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_dispatches"}, disp_cnt, exp_disp);
      chk({tag, "_sb_left"}, sb.size(), 0);
      chk({tag, "_hold"}, hold_bad, 0);
      chk({tag, "_addr_order"}, addr_back, 0);
      chk({tag, "_final_addr"}, {26'd0, bus.uop_addr}, exp_final);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"},    {31'd0, bus.rdy},       32'd1);
      chk({tag, "_addr"},   {26'd0, bus.uop_addr},  32'd0);
      chk({tag, "_dp_ena"}, {31'd0, bus.dp_ena},    32'd0);
      chk({tag, "_fields"}, {14'd0, bus.dp_opcode, bus.dp_src1, bus.dp_src2, bus.dp_dst}, 32'd0);
   endtask

   initial begin
      int w;
      rst         = 1'b1;
      bus.ena     = 1'b0;
      bus.dp_rdy  = 1'b0;
      bus.dp_flag = 1'b0;
      clear_rom();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("reset");
      last_cmd = '0;
      @(negedge clk);
      mon_en = 1'b1;

      // Init program, completion one cycle after each dispatch
      load_init();
      run_prog("init", 18, 3, 3, 0);

      // Second word completes 7 cycles after its dispatch
      load_init();
      slow_idx   = 1;
      slow_delay = 7;
      run_prog("slow", 24, 3, 3, 0);
      slow_idx   = -1;

      // Stray dp_rdy outside WAIT and repeated ena while busy
      load_init();
      noise      = 1'b1;
      base_delay = 3;
      run_prog("noise", 24, 3, 3, 5);
      noise      = 1'b0;
      base_delay = 1;

      // CMP false: IF_NOT_FLAG word dispatches, IF_FLAG word skipped
      load_cond();
      push(1, OPCODE_MOV, UOP_SRC_ONE, UOP_SRC_ZERO, UOP_DST_RZ);
      flag_cfg = 1'b0;
      run_prog("cmp0", 16, 2, 3, 0);

      // CMP true: IF_NOT_FLAG word skipped, IF_FLAG word dispatches
      load_cond();
      push(2, OPCODE_ADD, UOP_SRC_RX, UOP_SRC_RY, UOP_DST_RZ);
      flag_cfg = 1'b1;
      run_prog("cmp1", 16, 2, 3, 0);

      // Flag left at 1 above must be cleared by the new start
      clear_rom();
      rom[0] = uop_word(OPCODE_MUL, UOP_SRC_RX, UOP_SRC_RY, UOP_DST_RX, UOP_EXEC_IF_FLAG);
      rom[1] = uop_word(OPCODE_SUB, UOP_SRC_RY, UOP_SRC_RX, UOP_DST_RY, UOP_EXEC_IF_NOT_FLAG);
      rom[2] = '0;
      sb.delete();
      push(1, OPCODE_SUB, UOP_SRC_RY, UOP_SRC_RX, UOP_DST_RY);
      flag_cfg = 1'b0;
      run_prog("flagclr", 11, 1, 2, 0);

      // Reset in WAIT of word 1, then a clean rerun
      load_init();
      base_delay = 10;
      resp_idx   = 0;
      disp_cnt   = 0;
      @(negedge clk);
      bus.ena = 1'b1;
      @(negedge clk);
      bus.ena = 1'b0;
      w = 0;
      while (disp_cnt < 2 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("rstwait_reached", disp_cnt, 2);
      @(negedge clk);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("midrst");
      sb.delete();
      last_cmd   = '0;
      resp_cnt   = 0;
      base_delay = 1;
      @(negedge clk);
      mon_en = 1'b1;
      load_init();
      run_prog("rerun", 18, 3, 3, 0);

      // 64 MOVs with no RDY: ends at address 63 without wrapping
      clear_rom();
      sb.delete();
      for (int i = 0; i < 64; i++) begin
         rom[i] = uop_word(OPCODE_MOV, 4'(i >> 2), 4'(i + 1), 4'(i), UOP_EXEC_ALWAYS);
         push(i, OPCODE_MOV, 4'(i >> 2), 4'(i + 1), 4'(i));
      end
      run_prog("full64", 320, 64, 63, 0);
      @(negedge clk);
      chk("full64_idle_addr", {26'd0, bus.uop_addr}, 32'd63);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
